multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/multicycle_sequencer_pkg.sv | 78 +++++++
 rtl/multicycle_sequencer_if.sv | 37 +++
 rtl/multicycle_sequencer.sv | 96 +++++++++
 tb/tb_multicycle_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_sequencer_pkg
//  Description : State/class encodings and strobe decode for the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5,
    ST_HALT = 3'd7
  } state_e;

  // RET has no code of its own: the decoder presents it as CLS_JUMP.
  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_JUMP   = 3'd4,
    CLS_CALL   = 3'd5,
    CLS_NOP    = 3'd6,
    CLS_HALT   = 3'd7
  } cls_e;

  typedef struct packed {
    logic inst_en;
    logic reg_en;
    logic alu_en;
    logic mem_rd;
    logic mem_wr;
    logic reg_wr;
    logic pc_en;
    logic halted;
  } strobes_t;

  // Moore strobe decode from a state and the class latched for it.
  function automatic strobes_t decode_strobes(input state_e st, input cls_e cls);
    strobes_t s;
    s = '0;
    case (st)
      ST_IF: s.inst_en = 1'b1;
      ST_ID: begin
        s.reg_en = 1'b1;
        case (cls)
          CLS_JUMP, CLS_NOP: s.pc_en = 1'b1;
          CLS_CALL: begin
            s.pc_en  = 1'b1;
            s.reg_wr = 1'b1;
          end
          default: ;
        endcase
      end
      ST_EX: begin
        s.alu_en = 1'b1;
        if (cls == CLS_BRANCH) s.pc_en = 1'b1;
      end
      ST_MEM: begin
        s.mem_rd = (cls == CLS_LOAD);
        s.mem_wr = (cls == CLS_STORE);
      end
      ST_WB: begin
        s.reg_wr = 1'b1;
        s.pc_en  = 1'b1;
      end
      ST_HALT: s.halted = 1'b1;
      default: ;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_sequencer_if
//  Description : Decoder/memory-ready inputs and datapath strobes of the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [2:0]       iclass;
  logic             imem_ready;
  logic             dmem_ready;
  logic [2:0]       state;
  logic             inst_en;
  logic             reg_en;
  logic             alu_en;
  logic             mem_rd;
  logic             mem_wr;
  logic             reg_wr;
  logic             pc_en;
  logic             retired;
  logic             halted;
  logic [CNT_W-1:0] retire_count;

  modport master (
    output iclass, imem_ready, dmem_ready,
    input  state, inst_en, reg_en, alu_en, mem_rd, mem_wr, reg_wr, pc_en,
    input  retired, halted, retire_count
  );

  modport slave (
    input  iclass, imem_ready, dmem_ready,
    output state, inst_en, reg_en, alu_en, mem_rd, mem_wr, reg_wr, pc_en,
    output retired, halted, retire_count
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_sequencer
//  Description : Multicycle IF/ID/EX/MEM/WB control FSM with retire counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_sequencer_if.slave bus
);

  state_e           r_state;
  cls_e             r_cls;
  strobes_t         r_str;
  logic [CNT_W-1:0] r_count;

  state_e           w_next_state;
  cls_e             w_next_cls;
  logic             w_store_done;
  logic             w_pc_en;

  // The class is captured on the edge into ID so ID's own strobes can use it.
  always_comb begin
    w_next_state = r_state;
    w_next_cls   = r_cls;
    case (r_state)
      ST_IDLE: w_next_state = ST_IF;
      ST_IF: begin
        if (bus.imem_ready) begin
          w_next_state = ST_ID;
          w_next_cls   = cls_e'(bus.iclass);
        end
      end
      ST_ID: begin
        case (r_cls)
          CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH: w_next_state = ST_EX;
          CLS_HALT: w_next_state = ST_HALT;
          default:  w_next_state = ST_IF;
        endcase
      end
      ST_EX: begin
        case (r_cls)
          CLS_ALU:             w_next_state = ST_WB;
          CLS_LOAD, CLS_STORE: w_next_state = ST_MEM;
          default:             w_next_state = ST_IF;
        endcase
      end
      ST_MEM: begin
        if (bus.dmem_ready)
          w_next_state = (r_cls == CLS_LOAD) ? ST_WB : ST_IF;
      end
      ST_WB:   w_next_state = ST_IF;
      ST_HALT: w_next_state = ST_HALT;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // A STORE retires in the MEM cycle that dmem_ready completes it, which
  // cannot be known a cycle early, so that one pc_en term is combinational.
  assign w_store_done = (r_state == ST_MEM) && (r_cls == CLS_STORE) && bus.dmem_ready;
  assign w_pc_en      = r_str.pc_en | w_store_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cls   <= CLS_NOP;
      r_str   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_cls   <= w_next_cls;
      r_str   <= decode_strobes(w_next_state, w_next_cls);
      if (w_pc_en)
        r_count <= r_count + 1'b1;
    end
  end

  assign bus.state        = r_state;
  assign bus.inst_en      = r_str.inst_en;
  assign bus.reg_en       = r_str.reg_en;
  assign bus.alu_en       = r_str.alu_en;
  assign bus.mem_rd       = r_str.mem_rd;
  assign bus.mem_wr       = r_str.mem_wr;
  assign bus.reg_wr       = r_str.reg_wr;
  assign bus.pc_en        = w_pc_en;
  assign bus.retired      = w_pc_en;
  assign bus.halted       = r_str.halted;
  assign bus.retire_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_sequencer
//  Description : Directed and randomized checks against a step-queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multicycle_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_sequencer_if #(.CNT_W(16)) bus ();
  multicycle_sequencer_if #(.CNT_W(4))  bus4 ();

  assign bus4.iclass     = bus.iclass;
  assign bus4.imem_ready = bus.imem_ready;
  assign bus4.dmem_ready = bus.dmem_ready;

  multicycle_sequencer #(.CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
  multicycle_sequencer #(.CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

  // Strobe vector bit order: inst_en reg_en alu_en mem_rd mem_wr reg_wr pc_en halted
  localparam logic [7:0] S_INST = 8'h80, S_REG = 8'h40, S_ALU = 8'h20, S_RD = 8'h10;
  localparam logic [7:0] S_WR = 8'h08, S_RWR = 8'h04, S_PC = 8'h02, S_HLT = 8'h01;

  // wt: 0 none, 1 waits on imem, 2 waits on dmem, 3 never leaves
  typedef struct {
    int         st;
    logic [7:0] str;
    int         wt;
    bit         dec;
    bit         pr;
  } step_t;

  step_t       q[$];
  logic [15:0] m_count;
  int          errors = 0;
  int          checks = 0;
  logic [2:0]  tr_st[$];
  logic [7:0]  tr_str[$];
  logic        tr_ret[$];
  int          lat[7] = '{4, 5, 4, 3, 2, 2, 2};

  function automatic step_t mk(int st, logic [7:0] s, int wt, bit dec, bit pr);
    step_t r;
    r.st = st; r.str = s; r.wt = wt; r.dec = dec; r.pr = pr;
    return r;
  endfunction

  function automatic void m_reset();
    q.delete();
    q.push_back(mk(0, 8'h00, 0, 0, 0));
    m_count = 16'd0;
  endfunction

  // Sequence of stages an instruction walks through after its fetch.
  function automatic void push_class(int c);
    case (c)
      0: begin
        q.push_back(mk(2, S_REG, 0, 0, 0));
        q.push_back(mk(3, S_ALU, 0, 0, 0));
        q.push_back(mk(5, S_RWR | S_PC, 0, 0, 0));
      end
      1: begin
        q.push_back(mk(2, S_REG, 0, 0, 0));
        q.push_back(mk(3, S_ALU, 0, 0, 0));
        q.push_back(mk(4, S_RD, 2, 0, 0));
        q.push_back(mk(5, S_RWR | S_PC, 0, 0, 0));
      end
      2: begin
        q.push_back(mk(2, S_REG, 0, 0, 0));
        q.push_back(mk(3, S_ALU, 0, 0, 0));
        q.push_back(mk(4, S_WR, 2, 0, 1));
      end
      3: begin
        q.push_back(mk(2, S_REG, 0, 0, 0));
        q.push_back(mk(3, S_ALU | S_PC, 0, 0, 0));
      end
      5: q.push_back(mk(2, S_REG | S_PC | S_RWR, 0, 0, 0));
      7: begin
        q.push_back(mk(2, S_REG, 0, 0, 0));
        q.push_back(mk(7, S_HLT, 3, 0, 0));
      end
      default: q.push_back(mk(2, S_REG | S_PC, 0, 0, 0));
    endcase
  endfunction

  function automatic void m_advance();
    step_t f;
    bit    stay;
    if (reset) begin
      m_reset();
      return;
    end
    f = q[0];
    stay = (f.wt == 1 && !bus.imem_ready) || (f.wt == 2 && !bus.dmem_ready) || (f.wt == 3);
    if (f.str[1] || (f.pr && bus.dmem_ready)) m_count = m_count + 16'd1;
    if (!stay) begin
      void'(q.pop_front());
      if (f.dec) push_class(int'(bus.iclass));
      if (q.size() == 0) q.push_back(mk(1, S_INST, 1, 1, 0));
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Compare on the falling edge, then step the model across the next rising edge.
  task automatic cycle();
    step_t      f;
    logic       exp_pc;
    logic [7:0] exp_str, act_str;
    @(negedge clk);
    f       = q[0];
    exp_pc  = f.str[1] | (f.pr & bus.dmem_ready);
    exp_str = {f.str[7:2], exp_pc, f.str[0]};
    act_str = {bus.inst_en, bus.reg_en, bus.alu_en, bus.mem_rd,
               bus.mem_wr, bus.reg_wr, bus.pc_en, bus.halted};
    chk("state", 32'(bus.state), 32'(f.st));
    chk("strobes", 32'(act_str), 32'(exp_str));
    chk("retired", 32'(bus.retired), 32'(exp_pc));
    chk("count", 32'(bus.retire_count), 32'(m_count));
    chk("count4", 32'(bus4.retire_count), 32'(m_count[3:0]));
    tr_st.push_back(bus.state);
    tr_str.push_back(act_str);
    tr_ret.push_back(bus.retired);
    m_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_trace();
    tr_st.delete();
    tr_str.delete();
    tr_ret.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_reset();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    bus.iclass = 3'd6;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    do_reset();
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_count", 32'(bus.retire_count), 32'd0);

    // ALU, no waits
    bus.iclass = 3'd0;
    clear_trace();
    repeat (5) cycle();
    begin
      int ea[5] = '{0, 1, 2, 3, 5};
      for (int i = 0; i < 5; i++) chk("alu_seq", 32'(tr_st[i]), 32'(ea[i]));
    end
    chk("alu_wb_strobes", 32'(tr_str[4] & (S_RWR | S_PC)), 32'(S_RWR | S_PC));
    chk("alu_ex_no_pc", 32'(tr_str[3] & S_PC), 32'd0);
    chk("alu_count", 32'(bus.retire_count), 32'd1);

    // LOAD with two data wait cycles
    bus.iclass = 3'd1;
    bus.dmem_ready = 1'b0;
    clear_trace();
    repeat (5) cycle();
    bus.dmem_ready = 1'b1;
    repeat (2) cycle();
    begin
      int el[7] = '{1, 2, 3, 4, 4, 4, 5};
      for (int i = 0; i < 7; i++) chk("load_seq", 32'(tr_st[i]), 32'(el[i]));
    end
    n = 0; k = 0;
    for (int i = 0; i < 7; i++) begin
      n += int'(tr_str[i][4]);
      k += int'(tr_str[i][2]);
    end
    chk("load_mem_rd_cycles", 32'(n), 32'd3);
    chk("load_reg_wr_cycles", 32'(k), 32'd1);
    chk("load_count", 32'(bus.retire_count), 32'd2);

    // CALL
    bus.iclass = 3'd5;
    clear_trace();
    repeat (2) cycle();
    chk("call_seq0", 32'(tr_st[0]), 32'd1);
    chk("call_seq1", 32'(tr_st[1]), 32'd2);
    chk("call_id_link", 32'(tr_str[1] & (S_PC | S_RWR)), 32'(S_PC | S_RWR));
    chk("call_no_mem", 32'((tr_str[0] | tr_str[1]) & (S_RD | S_WR)), 32'd0);
    chk("call_count", 32'(bus.retire_count), 32'd3);

    // Zero-wait latency of every class
    for (int c = 0; c < 7; c++) begin
      bus.iclass = 3'(c);
      clear_trace();
      n = 0;
      do begin
        cycle();
        n++;
      end while (tr_ret[tr_ret.size()-1] !== 1'b1 && n < 12);
      chk("latency", 32'(n), 32'(lat[c]));
    end

    // Counter wrap on the narrow instance: 15 NOPs then a BRANCH
    do_reset();
    bus.iclass = 3'd6;
    cycle();
    repeat (30) cycle();
    chk("wrap_pre4", 32'(bus4.retire_count), 32'hF);
    chk("wrap_pre16", 32'(bus.retire_count), 32'd15);
    bus.iclass = 3'd3;
    repeat (3) cycle();
    chk("wrap_post4", 32'(bus4.retire_count), 32'd0);
    chk("wrap_post16", 32'(bus.retire_count), 32'd16);

    // Reset while a LOAD waits in MEM
    do_reset();
    bus.iclass = 3'd6;
    cycle();
    cycle();
    cycle();
    bus.iclass = 3'd1;
    bus.dmem_ready = 1'b0;
    repeat (4) cycle();
    chk("mid_mem_state", 32'(bus.state), 32'd4);
    chk("mid_mem_rd", 32'(bus.mem_rd), 32'd1);
    chk("mid_count", 32'(bus.retire_count), 32'd1);
    reset = 1'b1;
    m_reset();
    #1;
    chk("async_state", 32'(bus.state), 32'd0);
    chk("async_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("async_count", 32'(bus.retire_count), 32'd0);
    cycle();
    reset = 1'b0;
    bus.dmem_ready = 1'b1;
    clear_trace();
    repeat (2) cycle();
    chk("restart_idle", 32'(tr_st[0]), 32'd0);
    chk("restart_fetch", 32'(tr_str[1] & S_INST), 32'(S_INST));

    // STORE whose class input turns to HALT during EX
    do_reset();
    bus.iclass = 3'd2;
    repeat (3) cycle();
    bus.iclass = 3'd7;
    repeat (7) cycle();
    chk("halt_flag", 32'(bus.halted), 32'd1);
    chk("halt_state", 32'(bus.state), 32'd7);
    chk("halt_count", 32'(bus.retire_count), 32'd1);

    // Randomized traffic with waits, rare halts and rare resets
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      bus.imem_ready = ($urandom_range(0, 3) != 0);
      bus.dmem_ready = ($urandom_range(0, 2) != 0);
      bus.iclass     = ($urandom_range(0, 49) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      if ($urandom_range(0, 79) == 0) begin
        reset = 1'b1;
        m_reset();
      end else begin
        reset = 1'b0;
      end
      cycle();
    end

    // Drain into HALT and confirm it sticks with readies toggling
    reset = 1'b0;
    bus.iclass = 3'd7;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    repeat (12) cycle();
    for (int i = 0; i < 5; i++) begin
      bus.imem_ready = 1'($urandom_range(0, 1));
      bus.dmem_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    chk("final_halted", 32'(bus.halted), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
